mmio_io_responder: RTL and testbench

- Memory-mapped I/O responder for the CPU's data-memory port: answers loads and stores that fall in the I/O region (addr[31:28] == 4'h8).
- Bridges CPU accesses to the on-chip UART ready/valid ports using one-byte TX and RX holding registers.
- Provides cycle and retired-instruction counters.
- Read data returns one cycle after the access, matching block-RAM read latency, so the stage-3 read mux treats it like dmem/bios data.

---
 rtl/mmio_io_responder.sv | 105 ++++++++++
 tb/tb_mmio_io_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_io_responder.sv
`default_nettype none
// =============================================================================
// mmio_io_responder : CPU data-port I/O responder (UART holding regs, counters)
// Revision 1.0
// =============================================================================
module mmio_io_responder #(
   parameter logic [3:0] IO_REGION = 4'h8,
   parameter int          CNT_WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        mem_we,
   input  logic        mem_re,
   input  logic        instr_retire,
   output logic [31:0] io_rdata,
   output logic [7:0]  uart_tx_data,
   output logic        uart_tx_valid,
   input  logic        uart_tx_ready,
   input  logic [7:0]  uart_rx_data,
   input  logic        uart_rx_valid,
   output logic        uart_rx_ready
);

   localparam logic [7:0] OFF_STATUS = 8'h00;
   localparam logic [7:0] OFF_RX     = 8'h04;
   localparam logic [7:0] OFF_TX     = 8'h08;
   localparam logic [7:0] OFF_CYCLE  = 8'h10;
   localparam logic [7:0] OFF_INSTR  = 8'h14;
   localparam logic [7:0] OFF_CLR    = 8'h18;

   logic                 sel;
   logic [7:0]           offset;
   logic                 rx_full, rx_full_next, rx_push, rx_pop;
   logic                 tx_full, tx_accept, tx_done;
   logic                 cnt_clr;
   logic [7:0]           rx_byte, tx_byte;
   logic [CNT_WIDTH-1:0] cycle_cnt, instr_cnt;
   logic [31:0]          rd_mux;
   logic                 unused_bits;

   assign sel    = (mem_addr[31:28] == IO_REGION);
   assign offset = mem_addr[7:0];
   assign unused_bits = ^{mem_addr[27:8], mem_wdata[31:8]};

   // Ready is low while full, so a push and a pop never land on the same edge.
   assign rx_push      = uart_rx_valid && uart_rx_ready;
   assign rx_pop       = mem_re && sel && (offset == OFF_RX);
   assign rx_full_next = rx_push ? 1'b1 : (rx_pop ? 1'b0 : rx_full);

   // Accept only into an empty holder; a same-cycle handshake does not free it in time.
   assign tx_accept = mem_we && sel && (offset == OFF_TX) && !tx_full;
   assign tx_done   = tx_full && uart_tx_ready;
   assign cnt_clr   = mem_we && sel && (offset == OFF_CLR);

   assign uart_tx_valid = tx_full;
   assign uart_tx_data  = tx_byte;

   always_comb begin
      rd_mux = '0;
      case (offset)
         OFF_STATUS: rd_mux = {30'b0, rx_full, ~tx_full};
         OFF_RX:     rd_mux = {24'b0, rx_byte};
         OFF_CYCLE:  rd_mux = 32'(cycle_cnt);
         OFF_INSTR:  rd_mux = 32'(instr_cnt);
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         io_rdata      <= '0;
         rx_full       <= 1'b0;
         rx_byte       <= '0;
         uart_rx_ready <= 1'b0;
         tx_full       <= 1'b0;
         tx_byte       <= '0;
      end else begin
         io_rdata      <= (mem_re && sel) ? rd_mux : '0;
         rx_full       <= rx_full_next;
         uart_rx_ready <= ~rx_full_next;
         if (rx_push)
            rx_byte <= uart_rx_data;
         if (tx_accept) begin
            tx_full <= 1'b1;
            tx_byte <= mem_wdata[7:0];
         end else if (tx_done) begin
            tx_full <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
         instr_cnt <= instr_cnt + CNT_WIDTH'(instr_retire);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mmio_io_responder.sv
`default_nettype none
// =============================================================================
// tb_mmio_io_responder : directed self-checking bench for mmio_io_responder
// Revision 1.0
// =============================================================================
module tb_mmio_io_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic        instr_retire;
   logic [31:0] io_rdata;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_valid;
   logic        uart_tx_ready;
   logic [7:0]  uart_rx_data;
   logic        uart_rx_valid;
   logic        uart_rx_ready;

   int          n_checks = 0;
   int          n_fails  = 0;
   logic        saw_dropped = 1'b0;
   logic [31:0] rd;

   localparam logic [31:0] A_STATUS = 32'h8000_0000;
   localparam logic [31:0] A_RX     = 32'h8000_0004;
   localparam logic [31:0] A_TX     = 32'h8000_0008;
   localparam logic [31:0] A_CYCLE  = 32'h8000_0010;
   localparam logic [31:0] A_INSTR  = 32'h8000_0014;
   localparam logic [31:0] A_CLR    = 32'h8000_0018;

   mmio_io_responder dut (
      .clk           (clk),
      .rst           (rst),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_we        (mem_we),
      .mem_re        (mem_re),
      .instr_retire  (instr_retire),
      .io_rdata      (io_rdata),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_valid (uart_tx_valid),
      .uart_tx_ready (uart_tx_ready),
      .uart_rx_data  (uart_rx_data),
      .uart_rx_valid (uart_rx_valid),
      .uart_rx_ready (uart_rx_ready)
   );

   always #5 clk = ~clk;

   // Dropped TX bytes (0x42, 0x44) must never reach the transmitter.
   always @(negedge clk)
      if (uart_tx_data === 8'h42 || uart_tx_data === 8'h44)
         saw_dropped = 1'b1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d);
      mem_addr = a;
      mem_re   = 1'b1;
      tick();
      mem_re   = 1'b0;
      d        = io_rdata;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] wd);
      mem_addr  = a;
      mem_wdata = wd;
      mem_we    = 1'b1;
      tick();
      mem_we    = 1'b0;
   endtask

   initial begin
      rst = 1'b1; mem_addr = '0; mem_wdata = '0; mem_we = 1'b0; mem_re = 1'b0;
      instr_retire = 1'b0; uart_tx_ready = 1'b0; uart_rx_data = '0; uart_rx_valid = 1'b0;
      repeat (3) tick();
      check("reset_rdata",    io_rdata, 32'h0);
      check("reset_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
      check("reset_tx_data",  {24'b0, uart_tx_data}, 32'h0);
      check("reset_rx_ready", {31'b0, uart_rx_ready}, 32'h0);
      rst = 1'b0;

      // 1: cycle count after 10 idle edges, STATUS idle
      repeat (10) tick();
      check("rx_ready_after_rst", {31'b0, uart_rx_ready}, 32'h1);
      do_read(A_CYCLE, rd);   check("cycle_after_10", rd, 32'd10);
      do_read(A_STATUS, rd);  check("status_idle", rd, 32'h1);
      tick();
      check("rdata_zero_no_load", io_rdata, 32'h0);

      // 2: TX holding register, drop-while-full
      do_write(A_TX, 32'h41);
      check("tx_valid_set", {31'b0, uart_tx_valid}, 32'h1);
      check("tx_data_41",   {24'b0, uart_tx_data}, 32'h41);
      do_write(A_TX, 32'h42);
      check("tx_data_kept", {24'b0, uart_tx_data}, 32'h41);
      do_read(A_STATUS, rd);  check("status_tx_full", rd, 32'h0);
      uart_tx_ready = 1'b1;
      tick();
      uart_tx_ready = 1'b0;
      check("tx_valid_drop", {31'b0, uart_tx_valid}, 32'h0);
      do_read(A_STATUS, rd);  check("status_tx_empty", rd, 32'h1);
      do_write(A_TX, 32'h43);
      uart_tx_ready = 1'b1;
      do_write(A_TX, 32'h44);
      uart_tx_ready = 1'b0;
      check("tx_same_cycle_drop_valid", {31'b0, uart_tx_valid}, 32'h0);
      check("tx_same_cycle_drop_data",  {24'b0, uart_tx_data}, 32'h43);
      check("tx_dropped_never_seen", {31'b0, saw_dropped}, 32'h0);

      // 3: RX holding register
      uart_rx_data = 8'h5A; uart_rx_valid = 1'b1;
      tick();
      uart_rx_valid = 1'b0;
      check("rx_ready_fall", {31'b0, uart_rx_ready}, 32'h0);
      do_read(A_STATUS, rd);  check("status_rx_full", rd, 32'h3);
      do_read(A_RX, rd);      check("rx_data_5a", rd, 32'h5A);
      check("rx_ready_back", {31'b0, uart_rx_ready}, 32'h1);
      do_read(A_STATUS, rd);  check("status_rx_popped", rd, 32'h1);
      do_read(A_RX, rd);      check("rx_stale_read", rd, 32'h5A);
      do_read(A_STATUS, rd);  check("status_after_stale", rd, 32'h1);
      uart_rx_data = 8'h33; uart_rx_valid = 1'b1;
      tick();
      uart_rx_data = 8'h77;
      tick();
      uart_rx_valid = 1'b0;
      do_read(A_RX, rd);      check("rx_no_overwrite", rd, 32'h33);

      // 4: counters and CNT_RESET priority
      do_write(A_CLR, 32'h0);
      instr_retire = 1'b1;
      repeat (7) tick();
      instr_retire = 1'b0;
      do_read(A_INSTR, rd);   check("instr_7", rd, 32'd7);
      instr_retire = 1'b1;
      do_write(A_CLR, 32'hDEAD);
      instr_retire = 1'b0;
      do_read(A_CYCLE, rd);   check("cycle_cleared", rd, 32'd0);
      do_read(A_INSTR, rd);   check("instr_cleared", rd, 32'd0);
      do_read(A_CYCLE, rd);   check("cycle_resumes", rd, 32'd2);
      instr_retire = 1'b1;
      repeat (3) tick();
      instr_retire = 1'b0;
      do_read(A_INSTR, rd);   check("instr_resumes", rd, 32'd3);

      // 5: counter wrap, unselected and unmapped reads
      force dut.cycle_cnt = 32'hFFFF_FFFE;
      mem_addr = A_CYCLE;
      mem_re   = 1'b1;
      @(negedge clk);
      release dut.cycle_cnt;
      tick();  check("wrap_fffffffe", io_rdata, 32'hFFFF_FFFE);
      tick();  check("wrap_ffffffff", io_rdata, 32'hFFFF_FFFF);
      tick();  check("wrap_0",        io_rdata, 32'h0);
      tick();  check("wrap_1",        io_rdata, 32'h1);
      mem_re = 1'b0;
      do_read(32'h0000_0000, rd);  check("unselected_read", rd, 32'h0);
      do_read(32'h8000_0020, rd);  check("unmapped_read", rd, 32'h0);
      do_read(32'h8ABC_DE00, rd);  check("aliased_status", rd, 32'h1);
      do_write(32'h0000_0008, 32'h66);
      check("unselected_write", {31'b0, uart_tx_valid}, 32'h0);

      // 6: reset with both holding registers full
      do_write(A_TX, 32'h55);
      uart_rx_data = 8'h99; uart_rx_valid = 1'b1;
      tick();
      uart_rx_valid = 1'b0;
      check("pre_rst_tx_valid", {31'b0, uart_tx_valid}, 32'h1);
      check("pre_rst_rx_ready", {31'b0, uart_rx_ready}, 32'h0);
      rst = 1'b1; mem_addr = A_STATUS; mem_re = 1'b1;
      tick();
      rst = 1'b0; mem_re = 1'b0;
      check("rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
      check("rst_tx_data",  {24'b0, uart_tx_data}, 32'h0);
      check("rst_rx_ready", {31'b0, uart_rx_ready}, 32'h0);
      check("rst_rdata",    io_rdata, 32'h0);
      tick();
      check("post_rst_rx_ready", {31'b0, uart_rx_ready}, 32'h1);
      do_read(A_STATUS, rd);  check("post_rst_status", rd, 32'h1);
      do_read(A_RX, rd);      check("post_rst_rx_byte", rd, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
